decrementer: RTL and testbench
==============================

Name: decrementer

Overview:
- Free-running down-counter that times traffic-signal phases on the Nexys 3 board.
- Counts from a programmable start value down to 0, then reloads and repeats.
- Decrement rate is set by an internal clock-enable prescaler.
- Outputs feed the traffic-light FSM (phase timer) and the display logic.

Parameters:
- WIDTH, 4, bit width of the counter.
- START, 15, reload value after reset and after reaching 0; must fit in WIDTH bits.
- DIV, 1, number of clk cycles per decrement step; 1 means decrement every clock; legal range 1 to 2^32-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  count enable; when low, the counter and prescaler hold. Tie high for free-running use.
- load  input  1  synchronous load request.
- load_value  input  WIDTH  value captured when load=1.
- counter  output  WIDTH  current count (registered).
- zero  output  1  high while counter == 0 (combinational from counter).
- wrap  output  1  one-cycle pulse on the step where counter reloads from 0 to START.

Behaviour:
- Reset: when rst_n=0 at a rising clk edge:
  - counter <= START.
  - prescaler <= 0.
  - wrap <= 0.
  - Reset overrides load and en.
- Prescaler:
  - Counts 0..DIV-1 while en=1.
  - step=1 in the cycle where the prescaler is at DIV-1; the prescaler then returns to 0.
  - With DIV=1, step=1 every enabled cycle.
- Priority, highest first: reset > load > step.
- Load (load=1, rst_n=1):
  - counter <= load_value; prescaler <= 0; wrap <= 0.
  - Acts regardless of en.
- Step (en=1, step=1, no load):
  - counter > 0: counter <= counter-1; wrap <= 0.
  - counter == 0: counter <= START; wrap <= 1 for exactly one clk cycle.
- Hold (en=0, no load): counter and prescaler hold; wrap <= 0.
- Arithmetic: unsigned WIDTH-bit. No underflow to all-ones; 0 always reloads START.
- Default sequence (DIV=1, en=1): 15,14,...,1,0,15,...; period START+1 = 16 clocks; wrap pulses the cycle counter shows 15 after 0.
- Reset asserted mid-count: counter returns to START on the next edge; counting resumes the edge after rst_n rises.
- Simultaneous load and wrap condition: load wins; wrap stays 0.
- Outputs are never X after the first reset edge.

Decomposition:
- Shared package traffic_pkg:
  - CNT_W = 4
  - default START = 15
  - board clock constant CLK_HZ = 100_000_000, used to derive DIV for 1 s steps.
- One sub-module: clk_enable_div, the prescaler generating the step pulse.
- Counter/reload logic lives in decrementer.

Test Plan:
- Reset: rst_n=0 for 3 clocks -> counter=15, wrap=0, zero=0; release with en=1, DIV=1 -> counter reads 14, 13, ... on successive edges.
- Wrap: free-run 16 clocks after reset release -> counter sequence 14..0 then 15; wrap=1 only on the cycle counter becomes 15; zero=1 only when counter=0.
- Enable hold: en=0 for 5 clocks at counter=9 -> counter stays 9, wrap=0; en=1 -> next edge 8.
- Load priority: load=1, load_value=3 while counter=0 and en=1 -> counter=3, wrap=0; then 2, 1, 0, 15.
- Prescaler: DIV=4 -> counter changes every 4th clock (15 held 4 cycles, then 14); full period = 64 clocks.
- Mid-run reset: rst_n=0 at counter=6 -> next edge counter=15, prescaler cleared; reset held with load=1 -> counter still 15.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic-signal controller slice.
package traffic_pkg;

    // Width of the phase counter, and the count that follows reset and each wrap.
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned START_DEFAULT = 15;

    // Nexys 3 board oscillator frequency.
    localparam int unsigned CLK_HZ = 100_000_000;

    typedef logic [CNT_W-1:0] cnt_t;

    // Clock cycles per decrement step for a given step rate in Hz.
    // A rate of zero, or one above CLK_HZ, gives 1 (a step on every clock).
    function automatic int unsigned div_for_hz(input int unsigned step_hz);
        if (step_hz == 0 || step_hz > CLK_HZ) begin
            return 1;
        end
        return CLK_HZ / step_hz;
    endfunction

    // Prescale value for one step per second.
    localparam int unsigned DIV_1S = CLK_HZ;

endpackage

// File: rtl/clk_enable_div.sv
// Prescaler that produces a one-cycle step pulse once every DIV enabled clocks.
module clk_enable_div
    import traffic_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam logic [31:0] LAST = 32'(DIV - 1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // The step fires on the last enabled cycle of each DIV-cycle window.
    assign step = en && (cnt_q == LAST);

    // Next prescaler count: cleared by clr, held while disabled, wrapped after the step.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decrementer.sv
// Free-running down-counter that times traffic-signal phases.
// Counts START down to 0, then reloads START and pulses wrap for one cycle.
module decrementer
    import traffic_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W,
    parameter int unsigned START = START_DEFAULT,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             zero,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

    logic             step;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    logic             wrap_q;
    logic             wrap_d;

    // A load restarts the prescaler so the loaded value gets a full step window.
    clk_enable_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .step  (step)
    );

    // Next count: load beats step; zero reloads START instead of underflowing.
    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        if (load) begin
            counter_d = load_value;
        end else if (step) begin
            if (counter_q == '0) begin
                counter_d = START_V;
                wrap_d    = 1'b1;
            end else begin
                counter_d = counter_q - 1'b1;
            end
        end
    end

    // Counter and wrap registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q <= START_V;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
        end
    end

    assign counter = counter_q;
    assign wrap    = wrap_q;
    assign zero    = (counter_q == '0);

endmodule

// File: tb/tb_decrementer.sv
// Directed self-checking bench for decrementer, with DIV=1 and DIV=4 instances.
module tb_decrementer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] load_value;

    logic [3:0] counter1, counter4;
    logic       zero1, zero4;
    logic       wrap1, wrap4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decrementer #(.WIDTH(4), .START(15), .DIV(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .load_value (load_value),
        .counter    (counter1),
        .zero       (zero1),
        .wrap       (wrap1)
    );

    decrementer #(.WIDTH(4), .START(15), .DIV(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .load_value (load_value),
        .counter    (counter4),
        .zero       (zero4),
        .wrap       (wrap4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check1(input string tag, input logic [3:0] c, input logic w);
        check({tag, " counter"}, 32'(counter1), 32'(c));
        check({tag, " wrap"}, 32'(wrap1), 32'(w));
        check({tag, " zero"}, 32'(zero1), 32'(c == 4'd0));
    endtask

    task automatic check4(input string tag, input logic [3:0] c, input logic w);
        check({tag, " counter4"}, 32'(counter4), 32'(c));
        check({tag, " wrap4"}, 32'(wrap4), 32'(w));
        check({tag, " zero4"}, 32'(zero4), 32'(c == 4'd0));
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        load       = 1'b0;
        load_value = 4'd0;

        // Reset for 3 clocks.
        tick(3);
        check1("reset", 4'd15, 1'b0);
        check4("reset", 4'd15, 1'b0);

        // Free run: 14..0 then wrap to 15, then 14.
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check1("run", 4'(15 - i), 1'b0);
        end
        tick();
        check1("wrap", 4'd15, 1'b1);
        tick();
        check1("after_wrap", 4'd14, 1'b0);

        // Enable hold at 9.
        tick(5);
        check1("pre_hold", 4'd9, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("hold", 4'd9, 1'b0);
        end
        en = 1'b1;
        tick();
        check1("resume", 4'd8, 1'b0);

        // Load wins over the wrap condition at 0.
        tick(8);
        check1("at_zero", 4'd0, 1'b0);
        load       = 1'b1;
        load_value = 4'd3;
        tick();
        check1("load", 4'd3, 1'b0);
        load = 1'b0;
        tick(); check1("load_run", 4'd2, 1'b0);
        tick(); check1("load_run", 4'd1, 1'b0);
        tick(); check1("load_run", 4'd0, 1'b0);
        tick(); check1("load_wrap", 4'd15, 1'b1);

        // Load acts even while disabled.
        en         = 1'b0;
        load       = 1'b1;
        load_value = 4'd11;
        tick();
        check1("load_no_en", 4'd11, 1'b0);
        load = 1'b0;
        tick();
        check1("load_no_en_hold", 4'd11, 1'b0);
        en = 1'b1;

        // Mid-run reset at 6, then reset held together with load.
        tick(5);
        check1("pre_reset", 4'd6, 1'b0);
        rst_n = 1'b0;
        tick();
        check1("mid_reset", 4'd15, 1'b0);
        load       = 1'b1;
        load_value = 4'd3;
        tick();
        check1("reset_over_load", 4'd15, 1'b0);
        check4("reset_over_load", 4'd15, 1'b0);
        load  = 1'b0;
        rst_n = 1'b1;
        tick();
        check1("reset_release", 4'd14, 1'b0);
        check4("reset_release", 4'd15, 1'b0);

        // Prescaler DIV=4: each value held 4 clocks, full period 64 clocks.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i < 64; i++) begin
            tick();
            check4("div4", 4'(15 - i / 4), 1'b0);
        end
        tick();
        check4("div4_wrap", 4'd15, 1'b1);

        // Load mid-window restarts the prescaler.
        tick(2);
        check4("div4_mid", 4'd15, 1'b0);
        load       = 1'b1;
        load_value = 4'd5;
        tick();
        check4("div4_load", 4'd5, 1'b0);
        load = 1'b0;
        tick(3);
        check4("div4_load_hold", 4'd5, 1'b0);
        tick();
        check4("div4_load_step", 4'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
